// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding and default sizing for the bus arbiters.
package bus_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        WAIT = 2'b10,
        FREE = 2'b11
    } arb_state_e;
    localparam int N_REQ_DEF    = 4;
    localparam int HOLD_MAX_DEF = 64;
endpackage

// File: rtl/bus_rr_arbiter_if.sv
// bus_rr_arbiter_if: requester/bus-side signals of the round-robin arbiter.
interface bus_rr_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) ();
    localparam int IDX_W = $clog2(N_REQ);
    logic [N_REQ-1:0] req;
    logic             done;
    logic             dly;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_id;
    logic             bus_busy;
    logic             timeout;
    modport master (input req, done, dly, output gnt, gnt_id, bus_busy, timeout);
    modport slave  (output req, done, dly, input gnt, gnt_id, bus_busy, timeout);
endinterface

// File: rtl/bus_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request after the last owner wins.
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] win_o,
    output logic             valid_o
);
    // Scan from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        win_o = last_i;
        for (int i = N_REQ; i >= 1; i--)
            if (req_i[(int'(last_i) + i) % N_REQ]) win_o = IDX_W'((int'(last_i) + i) % N_REQ);
    end
    assign valid_o = |req_i;
endmodule

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin bus arbiter sequencing tenures through idle/busy/wait/free.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input logic              clk,
    input logic              rst_n,
    bus_rr_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);
    localparam logic [IDX_W-1:0] LAST_ID   = IDX_W'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] gnt_id_q, gnt_id_d, pick_id;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             busy_q, busy_d, tmo_q, tmo_d, pick_v, live;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i  (bus.req),
        .last_i (gnt_id_q),
        .win_o  (pick_id),
        .valid_o(pick_v)
    );

    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        hold_d   = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
        tmo_d    = 1'b0;
        case (state_q)
            IDLE, FREE: begin
                state_d  = pick_v ? BUSY : IDLE;
                gnt_id_d = pick_v ? pick_id : gnt_id_q;
                hold_d   = '0;
            end
            BUSY: begin
                if (bus.done) state_d = bus.dly ? WAIT : FREE;
                else if (hold_q == HOLD_LAST) begin
                    state_d = FREE;
                    tmo_d   = 1'b1;
                end
            end
            WAIT: begin
                hold_d  = hold_q;
                state_d = bus.dly ? WAIT : FREE;
            end
        endcase
        live   = (state_d == BUSY) || (state_d == WAIT);
        busy_d = live;
        gnt_d  = live ? (N_REQ'(1) << gnt_id_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_id_q <= LAST_ID;
            gnt_q    <= '0;
            hold_q   <= '0;
            busy_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            gnt_q    <= gnt_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.gnt_id   = gnt_id_q;
    assign bus.bus_busy = busy_q;
    assign bus.timeout  = tmo_q;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed plan plus random traffic against a tenure-level reference model.
module tb_bus_rr_arbiter;
    localparam int N    = 4;
    localparam int HOLD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    bus_rr_arbiter_if #(.N_REQ(N)) bus ();
    bus_rr_arbiter #(.N_REQ(N), .HOLD_MAX(HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference: owner, whether a tenure holds the bus, whether it is in delayed release.
    int m_owner, m_cycles;
    bit m_held, m_waiting, m_tmo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_owner(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) if (r[(last + i) % N]) return (last + i) % N;
        return last;
    endfunction

    task automatic model_reset();
        m_owner = N - 1; m_cycles = 0; m_held = 0; m_waiting = 0; m_tmo = 0;
    endtask

    task automatic model_step();
        m_tmo = 0;
        if (!rst_n) model_reset();
        else if (!m_held) begin
            if (bus.req != 0) begin
                m_owner = next_owner(bus.req, m_owner);
                m_held = 1; m_cycles = 0;
            end
        end else if (m_waiting) begin
            if (!bus.dly) begin m_held = 0; m_waiting = 0; end
        end else if (bus.done) begin
            if (bus.dly) m_waiting = 1; else m_held = 0;
        end else if (m_cycles == HOLD - 1) begin
            m_held = 0; m_tmo = 1;
        end else m_cycles++;
    endtask

    task automatic compare_model();
        check("gnt", 32'(bus.gnt), m_held ? 32'(1) << m_owner : 32'd0);
        check("gnt_id", 32'(bus.gnt_id), 32'(m_owner));
        check("bus_busy", 32'(bus.bus_busy), 32'(m_held));
        check("timeout", 32'(bus.timeout), 32'(m_tmo));
    endtask

    // A freshly released bus spends one turnaround cycle ungranted before re-arbitrating.
    bit m_turn;
    task automatic tick();
        bit was_held;
        was_held = m_held;
        if (m_turn) begin
            m_turn = 0;
            m_tmo = 0;
            if (!rst_n) model_reset();
            else if (bus.req != 0) begin
                m_owner = next_owner(bus.req, m_owner);
                m_held = 1; m_cycles = 0;
            end
        end else begin
            model_step();
            if (was_held && !m_held && rst_n) m_turn = 1;
        end
        if (!rst_n) m_turn = 0;
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; bus.req = '0; bus.done = 1'b0; bus.dly = 1'b0;
        model_reset(); m_turn = 0;
        repeat (2) @(posedge clk);
        #1;
        compare_model();
        check("rst_gnt_id", 32'(bus.gnt_id), 32'(N - 1));
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req = '0; bus.done = 1'b0; bus.dly = 1'b0;
        apply_reset();
        // single request, normal release
        bus.req = 4'b0100;
        tick();
        check("first_gnt", 32'(bus.gnt), 32'h4);
        check("first_id", 32'(bus.gnt_id), 32'd2);
        check("first_busy", 32'(bus.bus_busy), 32'd1);
        bus.req = '0; bus.done = 1'b1;
        tick();
        check("free_gnt", 32'(bus.gnt), 32'd0);
        bus.done = 1'b0;
        tick();
        check("idle_busy", 32'(bus.bus_busy), 32'd0);
        // strict rotation with all requesting
        apply_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            bus.done = 1'b0;
            tick();
            check("rot_id", 32'(bus.gnt_id), 32'(k % N));
            tick(); tick();
            bus.done = 1'b1;
            tick();
            check("rot_gap", 32'(bus.gnt), 32'd0);
        end
        // delayed release by owner 1
        bus.done = 1'b0; bus.req = 4'b0010;
        tick();
        check("wait_owner", 32'(bus.gnt), 32'h2);
        bus.done = 1'b1; bus.dly = 1'b1;
        tick();
        bus.done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wait_gnt", 32'(bus.gnt), 32'h2);
            check("wait_busy", 32'(bus.bus_busy), 32'd1);
        end
        bus.dly = 1'b0;
        tick();
        check("wait_free", 32'(bus.gnt), 32'd0);
        bus.req = '0;
        tick();
        // forced release after HOLD busy cycles
        apply_reset();
        bus.req = 4'b0001;
        tick();
        for (int k = 0; k < HOLD - 1; k++) begin
            tick();
            check("hold_no_tmo", 32'(bus.timeout), 32'd0);
        end
        tick();
        check("tmo_pulse", 32'(bus.timeout), 32'd1);
        check("tmo_gnt", 32'(bus.gnt), 32'd0);
        bus.req = 4'b0011;
        tick();
        check("tmo_next_id", 32'(bus.gnt_id), 32'd1);
        check("tmo_drop", 32'(bus.timeout), 32'd0);
        // done on the last allowed cycle wins over timeout
        for (int k = 0; k < HOLD - 1; k++) tick();
        bus.done = 1'b1;
        tick();
        check("edge_no_tmo", 32'(bus.timeout), 32'd0);
        check("edge_gnt", 32'(bus.gnt), 32'd0);
        bus.done = 1'b0;
        // asynchronous reset in WAIT with owner 3
        bus.req = 4'b1000;
        tick();
        check("rst_owner", 32'(bus.gnt_id), 32'd3);
        bus.done = 1'b1; bus.dly = 1'b1;
        tick();
        bus.done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_gnt", 32'(bus.gnt), 32'd0);
        check("async_busy", 32'(bus.bus_busy), 32'd0);
        bus.dly = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req = 4'b1001;
        tick();
        check("post_rst_id", 32'(bus.gnt_id), 32'd0);
        // random traffic
        for (int k = 0; k < 600; k++) begin
            bus.req  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            bus.done = ($urandom_range(0, 3) == 0);
            bus.dly  = ($urandom_range(0, 2) == 0);
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Shares one bus between N_REQ requesters with round-robin fairness.
- Sequences each bus tenure through idle, busy, wait (delayed release) and free (turnaround) phases.
- Grants exactly one requester at a time; the grant is held until the bus reports completion.
- Sits between requester masters and the shared bus; bus-side done/dly come from the current slave.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- IDX_W, $clog2(N_REQ), width of the owner index
- HOLD_MAX, 64, maximum cycles in BUSY before a forced release (timeout)
- CNT_W, $clog2(HOLD_MAX+1), width of the hold counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester bus request, level, held until granted and served
- done  in  1  current transfer complete (valid in BUSY only)
- dly  in  1  slave requests delayed release (sampled with done in BUSY, alone in WAIT)
- gnt  out  N_REQ  one-hot grant, registered
- gnt_id  out  IDX_W  index of the current/last owner
- bus_busy  out  1  high in BUSY or WAIT
- timeout  out  1  one-cycle pulse when a tenure is force-released

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. All flops are reset by it.
- Reset values:
  - state=IDLE; gnt=0; bus_busy=0; timeout=0.
  - gnt_id=N_REQ-1, so requester 0 has top priority after reset.
  - hold_cnt=0.
- State machine transitions (registered state; next-state logic is combinational):
  - IDLE: if req!=0, go to BUSY; winner chosen this cycle. Otherwise stay in IDLE.
  - BUSY:
    - !done and hold_cnt<HOLD_MAX-1: stay in BUSY.
    - done&&dly: go to WAIT.
    - done&&!dly: go to FREE.
    - !done and hold_cnt==HOLD_MAX-1: go to FREE, and timeout pulses on the cycle FREE is entered.
  - WAIT: while dly, stay in WAIT. When !dly, go to FREE. The hold counter does not advance in WAIT.
  - FREE (one-cycle turnaround):
    - If req!=0, go to BUSY with a new winner.
    - Otherwise go to IDLE.
- Arbitration:
  - Winner is the first asserted req scanning from (gnt_id+1) mod N_REQ upward, with wrap.
  - Arbitration occurs only on IDLE->BUSY and FREE->BUSY transitions.
  - gnt_id updates on entry to BUSY.
- Outputs:
  - gnt is one-hot at bit gnt_id while in BUSY or WAIT; zero in IDLE and FREE.
  - Latency: a req seen in IDLE is granted on the next edge, one cycle later.
  - Back-to-back tenures always have at least one FREE cycle with gnt=0.
  - bus_busy = (state==BUSY || state==WAIT), registered alongside state.
- Hold counter:
  - Cleared on entry to BUSY.
  - Increments each BUSY cycle, saturating.
  - Width CNT_W; no wrap.
- Boundary conditions:
  - Owner drops req mid-tenure: ignored; the tenure ends only on done or timeout.
  - All req high continuously: strict rotation 0,1,2,3,0...
  - done in IDLE, WAIT or FREE: ignored.
  - done and timeout in the same cycle: done wins; no timeout pulse.
  - dly without done in BUSY: ignored.
  - N_REQ not a power of two: pointer wraps at N_REQ-1 to 0, never indexing an unused bit.
  - rst_n asserted mid-tenure: immediate return to reset values. Grant drops asynchronously.

Decomposition:
- Shared package bus_arb_pkg holds:
  - state enum: IDLE=2'b00, BUSY=2'b01, WAIT=2'b10, FREE=2'b11 (same encoding as the existing bus FSM)
  - default N_REQ and HOLD_MAX constants
- One sub-module is natural: rr_pick.
  - Combinational round-robin priority picker.
  - Inputs: req vector and last-owner index. Outputs: winner index and valid.
  - Reused by other arbiters.

Test Plan:
- Reset then req=4'b0100 -> gnt=4'b0100 one cycle later, gnt_id=2, bus_busy=1. done=1,dly=0 -> FREE (gnt=0), then IDLE.
- req=4'b1111 held, done pulsed 3 cycles after each grant -> grant order 0,1,2,3,0. Exactly one gnt=0 cycle between tenures.
- Owner 1 in BUSY, done=1,dly=1, dly held 4 cycles -> WAIT for 4 cycles with gnt=4'b0010 and bus_busy=1, then FREE.
- HOLD_MAX=8, owner 0 never asserts done -> forced release after 8 BUSY cycles. timeout=1 for exactly one cycle entering FREE. Next grant goes to the next requester.
- done=1 on the exact cycle hold_cnt==HOLD_MAX-1 -> normal release, timeout stays 0.
- rst_n pulled low while in WAIT with owner 3 -> gnt=0 and bus_busy=0 immediately. After release, req=4'b1001 -> grant to 0, not 3.
